// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII control characters, fault codes and link/tx encodings
package xgmii_pkg;
  localparam logic [7:0] XGMII_IDLE = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_SEQ = 8'h9C;
  localparam logic [7:0] XGMII_SIG = 8'h5C;
  localparam logic [7:0] LF_CODE = 8'h01;
  localparam logic [7:0] RF_CODE = 8'h02;
  localparam logic [1:0] LS_OK = 2'b00;
  localparam logic [1:0] LS_LOCAL = 2'b01;
  localparam logic [1:0] LS_REMOTE = 2'b10;
  localparam logic [1:0] TX_NORMAL = 2'b00;
  localparam logic [1:0] TX_IDLE = 2'b01;
  localparam logic [1:0] TX_RFAULT = 2'b10;
  typedef enum logic [1:0] {FT_NONE = 2'd0, FT_LOCAL = 2'd1, FT_REMOTE = 2'd2} fault_type_t;
  function automatic logic [1:0] ls_of(fault_type_t t);
    return t == FT_LOCAL ? LS_LOCAL : t == FT_REMOTE ? LS_REMOTE : LS_OK;
  endfunction
  function automatic logic [1:0] tx_of(logic [1:0] s);
    return s == LS_LOCAL ? TX_RFAULT : s == LS_REMOTE ? TX_IDLE : TX_NORMAL;
  endfunction
endpackage

// File: rtl/xgmii_fault_seq_detect.sv
// xgmii_fault_seq_detect: classifies one XGMII column as local/remote fault ordered set
module xgmii_fault_seq_detect
  import xgmii_pkg::*;
(
  input  logic [31:0] xgmii_data,
  input  logic [3:0]  xgmii_ctl,
  output logic        is_fault,
  output fault_type_t fault_type
);
  assign is_fault = xgmii_ctl == 4'b0001 && xgmii_data[23:0] == {16'h0000, XGMII_SEQ} &&
                    (xgmii_data[31:24] == LF_CODE || xgmii_data[31:24] == RF_CODE);
  assign fault_type = !is_fault ? FT_NONE : xgmii_data[31:24] == LF_CODE ? FT_LOCAL : FT_REMOTE;
endmodule

// File: rtl/xgmii_link_fault_ctrl.sv
// xgmii_link_fault_ctrl: RX link fault state machine; LINK_FAULT_STATS_EN enables fault-entry counters
module xgmii_link_fault_ctrl
  import xgmii_pkg::*;
#(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int FAULT_SEQ_THRESH = 4,
  parameter int FAULT_CLEAR_COLS = 128
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst,
  input  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data,
  input  logic [3:0]                  in_xgmii_ctl,
  output logic [1:0]                  link_status,
  output logic                        rx_enable,
  output logic [1:0]                  tx_mode,
  output logic                        status_change,
  output logic [15:0]                 local_fault_cnt,
  output logic [15:0]                 remote_fault_cnt
);
  localparam logic [7:0] CLR = 8'(FAULT_CLEAR_COLS);
  localparam logic [2:0] THR = 3'(FAULT_SEQ_THRESH);
  fault_type_t ft, last_type, last_nxt;
  logic is_fault, clr, idle_col;
  logic [2:0] seq_cnt, seq_nxt;
  logic [7:0] col_cnt, col_nxt;
  logic [1:0] status_nxt;
  xgmii_fault_seq_detect u_det (
    .xgmii_data(in_xgmii_data[31:0]),
    .xgmii_ctl(in_xgmii_ctl),
    .is_fault(is_fault),
    .fault_type(ft)
  );
  assign idle_col = in_xgmii_ctl == 4'hF && in_xgmii_data[31:0] == {4{XGMII_IDLE}};
  always_comb begin
    col_nxt = is_fault ? 8'd0 : col_cnt == CLR ? col_cnt : col_cnt + 8'd1;
    clr = !is_fault && col_nxt == CLR;
    seq_nxt = clr ? 3'd0 : !is_fault ? seq_cnt : ft != last_type ? 3'd1 :
              seq_cnt == 3'd7 ? seq_cnt : seq_cnt + 3'd1;
    last_nxt = clr ? FT_NONE : is_fault ? ft : last_type;
    status_nxt = clr ? LS_OK : is_fault && seq_nxt >= THR ? ls_of(ft) : link_status;
  end
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      link_status <= LS_OK;
      tx_mode <= TX_NORMAL;
      rx_enable <= 1'b0;
      status_change <= 1'b0;
      seq_cnt <= 3'd0;
      col_cnt <= 8'd0;
      last_type <= FT_NONE;
    end else begin
      link_status <= status_nxt;
      tx_mode <= tx_of(status_nxt);
      rx_enable <= status_nxt != LS_OK ? 1'b0 : idle_col ? 1'b1 : rx_enable;
      status_change <= status_nxt != link_status;
      seq_cnt <= seq_nxt;
      col_cnt <= col_nxt;
      last_type <= last_nxt;
    end
  end
`ifdef LINK_FAULT_STATS_EN
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      local_fault_cnt <= 16'h0000;
      remote_fault_cnt <= 16'h0000;
    end else begin
      if (status_nxt == LS_LOCAL && link_status != LS_LOCAL && local_fault_cnt != 16'hFFFF)
        local_fault_cnt <= local_fault_cnt + 16'd1;
      if (status_nxt == LS_REMOTE && link_status != LS_REMOTE && remote_fault_cnt != 16'hFFFF)
        remote_fault_cnt <= remote_fault_cnt + 16'd1;
    end
  end
`else
  assign local_fault_cnt = 16'h0000;
  assign remote_fault_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_xgmii_link_fault_ctrl.sv
// tb_xgmii_link_fault_ctrl: directed self-checking bench for xgmii_link_fault_ctrl
module tb_xgmii_link_fault_ctrl;
`ifdef LINK_FAULT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic rx_clk = 1'b0;
  logic rx_rst = 1'b1;
  logic [31:0] in_xgmii_data = 32'h07070707;
  logic [3:0] in_xgmii_ctl = 4'hF;
  logic [1:0] link_status, tx_mode;
  logic rx_enable, status_change;
  logic [15:0] local_fault_cnt, remote_fault_cnt;
  int n_chk = 0;
  int n_err = 0;
  xgmii_link_fault_ctrl dut (
    .rx_clk(rx_clk),
    .rx_rst(rx_rst),
    .in_xgmii_data(in_xgmii_data),
    .in_xgmii_ctl(in_xgmii_ctl),
    .link_status(link_status),
    .rx_enable(rx_enable),
    .tx_mode(tx_mode),
    .status_change(status_change),
    .local_fault_cnt(local_fault_cnt),
    .remote_fault_cnt(remote_fault_cnt)
  );
  always #5 rx_clk = ~rx_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic col(input logic [31:0] d, input logic [3:0] c);
    in_xgmii_data = d;
    in_xgmii_ctl = c;
    @(posedge rx_clk);
    #1;
  endtask
  task automatic lf();
    col(32'h0100009C, 4'b0001);
  endtask
  task automatic rf();
    col(32'h0200009C, 4'b0001);
  endtask
  task automatic idle();
    col(32'h07070707, 4'hF);
  endtask
  task automatic dat();
    col(32'h55555555, 4'h0);
  endtask
  initial begin
    repeat (2) idle();
    chk("rst_status", link_status, 2'b00);
    chk("rst_tx", tx_mode, 2'b00);
    chk("rst_rxen", rx_enable, 1'b0);
    chk("rst_sc", status_change, 1'b0);
    chk("rst_lcnt", local_fault_cnt, 16'h0);
    chk("rst_rcnt", remote_fault_cnt, 16'h0);
    rx_rst = 1'b0;
    idle();
    chk("idle_rxen", rx_enable, 1'b1);
    repeat (3) lf();
    chk("lf3_status", link_status, 2'b00);
    chk("lf3_sc", status_change, 1'b0);
    lf();
    chk("lf4_status", link_status, 2'b01);
    chk("lf4_tx", tx_mode, 2'b10);
    chk("lf4_rxen", rx_enable, 1'b0);
    chk("lf4_sc", status_change, 1'b1);
    lf();
    chk("lf5_status", link_status, 2'b01);
    chk("lf5_sc", status_change, 1'b0);
    chk("lf_cnt1", local_fault_cnt, 16'(STATS));
    repeat (127) idle();
    chk("clr127_status", link_status, 2'b01);
    chk("clr127_rxen", rx_enable, 1'b0);
    idle();
    chk("clr128_status", link_status, 2'b00);
    chk("clr128_rxen", rx_enable, 1'b1);
    chk("clr128_sc", status_change, 1'b1);
    chk("clr128_tx", tx_mode, 2'b00);
    repeat (3) lf();
    rf();
    repeat (2) rf();
    chk("mix_status", link_status, 2'b00);
    rf();
    chk("rf4_status", link_status, 2'b10);
    chk("rf4_tx", tx_mode, 2'b01);
    chk("rf4_sc", status_change, 1'b1);
    chk("rf_cnt1", remote_fault_cnt, 16'(STATS));
    repeat (3) lf();
    chk("r2l3_status", link_status, 2'b10);
    lf();
    chk("r2l_status", link_status, 2'b01);
    chk("r2l_tx", tx_mode, 2'b10);
    chk("r2l_sc", status_change, 1'b1);
    repeat (3) rf();
    col(32'h0300009C, 4'b0001);
    col(32'h0100009C, 4'b0011);
    chk("odd9c_status", link_status, 2'b01);
    rf();
    chk("l2r_status", link_status, 2'b10);
    chk("l2r_tx", tx_mode, 2'b01);
    repeat (127) dat();
    chk("dclr127_status", link_status, 2'b10);
    dat();
    chk("dclr128_status", link_status, 2'b00);
    chk("dclr128_rxen", rx_enable, 1'b0);
    chk("dclr128_sc", status_change, 1'b1);
    dat();
    chk("mid_frame_rxen", rx_enable, 1'b0);
    idle();
    chk("frame_end_rxen", rx_enable, 1'b1);
    repeat (4) lf();
    chk("lf_third", link_status, 2'b01);
    chk("lf_cnt3", local_fault_cnt, 16'(3 * STATS));
    chk("rf_cnt2", remote_fault_cnt, 16'(2 * STATS));
    repeat (127) idle();
    idle();
    repeat (2) lf();
    rx_rst = 1'b1;
    idle();
    rx_rst = 1'b0;
    chk("mrst_status", link_status, 2'b00);
    chk("mrst_lcnt", local_fault_cnt, 16'h0);
    chk("mrst_rcnt", remote_fault_cnt, 16'h0);
    chk("mrst_rxen", rx_enable, 1'b0);
    repeat (3) lf();
    chk("mrst_lf3", link_status, 2'b00);
    lf();
    chk("mrst_lf4", link_status, 2'b01);
    chk("mrst_cnt", local_fault_cnt, 16'(STATS));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/xgmii_link_fault_ctrl.md
XGMII_LINK_FAULT_CTRL -- requirements
Module: xgmii_link_fault_ctrl

Interface
REQ-001 SHALL have parameter XGMII_DATA_WIDTH, default 32, XGMII bus width; only 32 is supported (one column per cycle).
REQ-002 SHALL have parameter FAULT_SEQ_THRESH, default 4, number of same-type fault columns needed to declare a fault.
REQ-003 SHALL have parameter FAULT_CLEAR_COLS, default 128, number of consecutive non-fault columns needed to clear a fault.
REQ-004 SHALL have port rx_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rx_rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port in_xgmii_data  input  32  RX XGMII data, lane 0 = bits [7:0].
REQ-007 SHALL have port in_xgmii_ctl  input  4  RX XGMII control flags, one per lane.
REQ-008 SHALL have port link_status  output  2  00 OK, 01 local fault, 10 remote fault.
REQ-009 SHALL have port rx_enable  output  1  gates the RX MAC; 1 = frame reception allowed.
REQ-010 SHALL have port tx_mode  output  2  00 normal, 01 send idle, 10 send remote-fault sequences.
REQ-011 SHALL have port status_change  output  1  one-cycle pulse on every link_status change.
REQ-012 SHALL have ports local_fault_cnt and remote_fault_cnt  output  16 each  fault-entry statistics.

Function
REQ-013 SHALL classify a column as a fault column when ctl==4'b0001, lane0==8'h9C, lane1==8'h00, lane2==8'h00 and lane3 is 8'h01 (local) or 8'h02 (remote); every other column, including 9C with another lane3 value, is a non-fault column.
REQ-014 SHALL hold internal state: last_seq_type (none/local/remote), seq_cnt (3-bit, saturating at 7) and col_cnt (8-bit, saturating at FAULT_CLEAR_COLS).
REQ-015 On a fault column SHALL clear col_cnt. If its type equals last_seq_type, seq_cnt increments; otherwise seq_cnt becomes 1 and last_seq_type takes the new type.
REQ-016 SHALL set link_status to the column's type on the edge that samples the column making the same-type count reach FAULT_SEQ_THRESH (latency 1 cycle); further same-type columns hold the status.
REQ-017 On a non-fault column SHALL increment col_cnt. On the edge sampling the FAULT_CLEAR_COLS-th consecutive non-fault column it SHALL set link_status OK, seq_cnt 0 and last_seq_type none.
REQ-018 SHALL apply a threshold-reaching sequence of the other type to link_status directly (local->remote, remote->local) without passing through OK.
REQ-019 SHALL drive tx_mode registered from the next link_status: OK->00, local->10, remote->01, updating on the same edge as link_status.
REQ-020 SHALL assert status_change for exactly one cycle, coincident with the first cycle the new link_status value is visible.
REQ-021 SHALL deassert rx_enable on the same edge link_status leaves OK.
REQ-022 SHALL reassert rx_enable only on an edge where link_status is OK and the sampled column is all-idle (ctl==4'hF, data==32'h07070707), so reception never resumes mid-frame.
REQ-023 SHALL increment local_fault_cnt or remote_fault_cnt once per entry into that state, saturating at 16'hFFFF.

Reset
REQ-024 On rx_rst high SHALL set link_status=00, tx_mode=00, rx_enable=0, status_change=0, seq_cnt=0, col_cnt=0, last_seq_type=none and both statistics counters to 0.
REQ-025 SHALL let reset asserted mid-sequence discard any partial seq_cnt/col_cnt progress; the first post-reset cycle behaves as after power-up.

Configuration
REQ-026 With macro LINK_FAULT_STATS_EN defined SHALL implement REQ-023. Without it, both counter ports SHALL remain present and tie to 16'h0000, with no counter flops.

Structure
REQ-027 SHALL place the XGMII control character constants (07, FB, FD, FE, 9C, 5C), the fault-type codes, and the link_status and tx_mode encodings in shared package xgmii_pkg.
REQ-028 SHALL use one combinational sub-module, xgmii_fault_seq_detect, that outputs is_fault and fault_type per column.

Verification
REQ-029 Reset then 4 local-fault columns -> link_status=01 and tx_mode=10 on the edge after the 4th column, rx_enable=0, status_change pulses once.
REQ-030 3 local columns then 1 remote column then 3 remote columns -> status stays 00 until the 4th remote column, then becomes 10 and tx_mode becomes 01.
REQ-031 Local fault declared, then 127 idle columns -> status remains 01; 128th idle column -> status 00, and rx_enable=1 on that same edge.
REQ-032 Status OK but traffic mid-frame (data columns) -> rx_enable stays 0 until the first all-idle column, then rises on that edge.
REQ-033 Enter local fault 3 times (compiled with LINK_FAULT_STATS_EN) -> local_fault_cnt=3; without the macro -> 0. rx_rst pulsed during a 2-column sequence -> counts cleared and 4 fresh columns are required.
